// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master engines.
//   i2c_state_e : write-engine FSM states
//   Q0..Q3      : quarter-bit phase codes (Q0 SCL low/drive SDA, Q1-Q2 SCL
//                 released, sample at end of Q2, Q3 SCL low)
//   ADDR_W      : 7-bit I2C address width
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_STOP
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int ADDR_W = 7;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: free-running divider producing a 1-clk tick every CLK_DIV
// clocks; one tick = one SCL quarter period.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (counter cleared, tick low)
//   tick out 1-cycle pulse every CLK_DIV clocks
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/i2c_fifo_tx.sv
// i2c_fifo_tx: I2C master write engine draining a byte FIFO.
// Whenever the FIFO holds data (and enable is high) it issues START, addr+W,
// then pops and sends bytes until the FIFO is empty or the slave NACKs, then
// STOP. Open-drain pads: *_oe=1 pulls the line low.
//   clk, rst            system clock, asynchronous active-high reset
//   enable              permits a new transaction to leave IDLE
//   slave_addr[6:0]     target address, latched at START
//   fifo_data[D-1:0]    FIFO head, valid while !fifo_empty
//   fifo_empty          FIFO empty flag
//   fifo_rd             1-clk pop pulse per consumed byte
//   scl_i, sda_i        pad inputs
//   scl_oe, sda_oe      pad pull-down enables (registered)
//   busy                START through STOP completion
//   nack                sticky slave-NACK flag, cleared at START
// Build option: define I2C_TX_STRETCH_EN to honour slave clock stretching
// (phase counter holds in Q1/Q2 while SCL is released but still low).
module i2c_fifo_tx
  import i2c_pkg::*;
#(
  parameter int D       = 8,
  parameter int CLK_DIV = 250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic [D-1:0]      fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic              busy,
  output logic              nack
);

  i2c_state_e        state, state_nx;
  logic [1:0]        phase;
  logic [2:0]        bitcnt;
  logic [D-1:0]      shreg;
  logic [ADDR_W-1:0] addr_q;
  logic              nack_smp;   // sda_i captured at end of Q2 (1 = NACK)
  logic              tick, adv, end_bit, start_go;
  logic              scl_d, sda_d;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef I2C_TX_STRETCH_EN
  // While we have released SCL in Q1/Q2 but it still reads low, a slave is
  // stretching: freeze the phase until it lets go.
  assign adv = tick && !((phase == Q1 || phase == Q2) && !scl_oe && !scl_i);
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign adv        = tick;
`endif

  assign end_bit  = adv && (phase == Q3);
  assign start_go = (state == S_IDLE) && (state_nx == S_START);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (tick && enable && !fifo_empty) state_nx = S_START;
      S_START:    if (end_bit) state_nx = S_ADDR;
      S_ADDR:     if (end_bit && bitcnt == 3'd7) state_nx = S_ADDR_ACK;
      S_ADDR_ACK,
      S_DATA_ACK: if (end_bit) state_nx = (nack_smp || fifo_empty) ? S_STOP : S_DATA;
      S_DATA:     if (end_bit && bitcnt == 3'd7) state_nx = S_DATA_ACK;
      S_STOP:     if (end_bit) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // outputs: pop strobe and next pad enables
  always_comb begin
    fifo_rd = end_bit && (state == S_ADDR_ACK || state == S_DATA_ACK) &&
              !nack_smp && !fifo_empty;
    scl_d   = 1'b0;
    sda_d   = 1'b0;
    case (state)
      S_START: begin            // SDA falls in Q2 with SCL high
        scl_d = (phase == Q3);
        sda_d = (phase == Q2 || phase == Q3);
      end
      S_ADDR, S_DATA: begin
        scl_d = (phase == Q0 || phase == Q3);
        sda_d = ~shreg[D-1];
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        scl_d = (phase == Q0 || phase == Q3);
      end
      S_STOP: begin             // SDA rises in Q3 with SCL high
        scl_d = (phase == Q0);
        sda_d = (phase != Q3);
      end
      default: ;
    endcase
  end

  // datapath and registered pad drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= Q0;
      bitcnt   <= '0;
      shreg    <= '0;
      addr_q   <= '0;
      nack_smp <= 1'b0;
      busy     <= 1'b0;
      nack     <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      scl_oe <= scl_d;
      sda_oe <= sda_d;

      if (start_go) begin
        addr_q <= slave_addr;
        nack   <= 1'b0;
        busy   <= 1'b1;
        phase  <= Q0;
      end else if (state != S_IDLE && adv) begin
        phase <= phase + 2'd1;
      end

      if (adv && phase == Q2) nack_smp <= sda_i;

      if (end_bit) begin
        case (state)
          S_START: begin
            shreg  <= D'({addr_q, 1'b0});
            bitcnt <= '0;
          end
          S_ADDR, S_DATA: begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt + 3'd1;   // 7 -> 0 leaves it ready for the next byte
          end
          S_ADDR_ACK, S_DATA_ACK: if (nack_smp) nack <= 1'b1;
          S_STOP:  busy <= 1'b0;
          default: ;
        endcase
      end

      // byte capture coincides with the pop strobe
      if (fifo_rd) shreg <= fifo_data;
    end
  end

endmodule
